// File: rtl/dds_tuning_loader.sv
// Frequency-index to DDS tuning-word loader with phase accumulator.
// A shift-add multiply builds the word; the commit waits for an accumulator wrap so phase stays continuous.
module dds_tuning_loader #(
  parameter int              ACC_W    = 32,
  parameter int              PHASE_W  = 12,
  parameter int              K_W      = 20,
  parameter logic [K_W-1:0]  K_SCALE  = 20'd2237,
  parameter int              MAX_ADDR = 1800
) (
  input  logic               Fg_CLK,
  input  logic               RESETn,
  input  logic [11:0]        Address,
  input  logic               FreqChng,
  output logic [PHASE_W-1:0] PhaseOut,
  output logic [ACC_W-1:0]   TuneWord,
  output logic               Busy,
  output logic               Loaded
);

  localparam int          PROD_W     = 12 + K_W;
  localparam logic [11:0] MAX_ADDR_V = 12'(MAX_ADDR);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_MUL  = 2'd1;
  localparam logic [1:0] ST_WAIT = 2'd2;

  logic [ACC_W-1:0]  acc_r;
  logic [ACC_W-1:0]  tune_word_r;
  logic [PROD_W-1:0] prod_r;
  logic [11:0]       addr_r;
  logic [3:0]        bit_cnt_r;
  logic [1:0]        state_r;
  logic              pending_r;
  logic              busy_r;
  logic              loaded_r;

  logic [ACC_W:0]    acc_sum_s;
  logic              wrap_s;
  logic [11:0]       addr_clamp_s;
  logic [PROD_W-1:0] part_prod_s;

  logic [ACC_W-1:0]  tune_word_nxt_s;
  logic [PROD_W-1:0] prod_nxt_s;
  logic [11:0]       addr_nxt_s;
  logic [3:0]        bit_cnt_nxt_s;
  logic [1:0]        state_nxt_s;
  logic              pending_nxt_s;
  logic              loaded_nxt_s;

  assign acc_sum_s    = {1'b0, acc_r} + {1'b0, tune_word_r};
  assign wrap_s       = acc_sum_s[ACC_W];
  assign addr_clamp_s = (Address > MAX_ADDR_V) ? MAX_ADDR_V : Address;
  assign part_prod_s  = {{(PROD_W-K_W){1'b0}}, K_SCALE} << bit_cnt_r;

  // Load sequencer: capture, multiply LSB-first, then hold the word until a wrap (or a stalled accumulator).
  always_comb begin
    state_nxt_s     = state_r;
    prod_nxt_s      = prod_r;
    addr_nxt_s      = addr_r;
    bit_cnt_nxt_s   = bit_cnt_r;
    pending_nxt_s   = pending_r;
    tune_word_nxt_s = tune_word_r;
    loaded_nxt_s    = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (FreqChng) begin
          addr_nxt_s    = addr_clamp_s;
          prod_nxt_s    = {PROD_W{1'b0}};
          bit_cnt_nxt_s = 4'd0;
          pending_nxt_s = 1'b0;
          state_nxt_s   = ST_MUL;
        end else begin
          state_nxt_s   = ST_IDLE;
        end
      end
      ST_MUL: begin
        if (addr_r[bit_cnt_r]) begin
          prod_nxt_s = prod_r + part_prod_s;
        end else begin
          prod_nxt_s = prod_r;
        end
        if (bit_cnt_r == 4'd11) begin
          state_nxt_s = ST_WAIT;
        end else begin
          bit_cnt_nxt_s = bit_cnt_r + 4'd1;
        end
        if (FreqChng) begin
          pending_nxt_s = 1'b1;
        end else begin
          pending_nxt_s = pending_r;
        end
      end
      ST_WAIT: begin
        // With a zero word the accumulator never carries, so commit without waiting.
        if (wrap_s || (tune_word_r == {ACC_W{1'b0}})) begin
          tune_word_nxt_s = prod_r[ACC_W-1:0];
          loaded_nxt_s    = 1'b1;
          if (pending_r || FreqChng) begin
            addr_nxt_s    = addr_clamp_s;
            prod_nxt_s    = {PROD_W{1'b0}};
            bit_cnt_nxt_s = 4'd0;
            pending_nxt_s = 1'b0;
            state_nxt_s   = ST_MUL;
          end else begin
            state_nxt_s   = ST_IDLE;
          end
        end else if (FreqChng) begin
          pending_nxt_s = 1'b1;
        end else begin
          pending_nxt_s = pending_r;
        end
      end
      default: begin
        state_nxt_s   = ST_IDLE;
        pending_nxt_s = 1'b0;
      end
    endcase
  end

  // State, datapath and output registers.
  always_ff @(posedge Fg_CLK or negedge RESETn) begin
    if (!RESETn) begin
      acc_r       <= {ACC_W{1'b0}};
      tune_word_r <= {ACC_W{1'b0}};
      prod_r      <= {PROD_W{1'b0}};
      addr_r      <= 12'd0;
      bit_cnt_r   <= 4'd0;
      state_r     <= ST_IDLE;
      pending_r   <= 1'b0;
      busy_r      <= 1'b0;
      loaded_r    <= 1'b0;
    end else begin
      acc_r       <= acc_sum_s[ACC_W-1:0];
      tune_word_r <= tune_word_nxt_s;
      prod_r      <= prod_nxt_s;
      addr_r      <= addr_nxt_s;
      bit_cnt_r   <= bit_cnt_nxt_s;
      state_r     <= state_nxt_s;
      pending_r   <= pending_nxt_s;
      busy_r      <= (state_nxt_s != ST_IDLE);
      loaded_r    <= loaded_nxt_s;
    end
  end

  assign PhaseOut = acc_r[ACC_W-1 -: PHASE_W];
  assign TuneWord = tune_word_r;
  assign Busy     = busy_r;
  assign Loaded   = loaded_r;

endmodule

// File: tb/tb_dds_tuning_loader.sv
// Directed bench for dds_tuning_loader: a table of loads plus hand-written collision and reset sequences.
// A behavioural accumulator/load model checks PhaseOut, TuneWord, Busy and Loaded after every edge.
module tb_dds_tuning_loader;

  logic        clk;
  logic        rst_n;
  logic [11:0] addr;
  logic        fc;
  logic [11:0] phase_out;
  logic [31:0] tune_word;
  logic        busy;
  logic        loaded;

  dds_tuning_loader dut (
    .Fg_CLK   (clk),
    .RESETn   (rst_n),
    .Address  (addr),
    .FreqChng (fc),
    .PhaseOut (phase_out),
    .TuneWord (tune_word),
    .Busy     (busy),
    .Loaded   (loaded)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [11:0] addr;
    logic [31:0] tw;
  } vec_t;

  vec_t vecs [5];

  int checks = 0;
  int errors = 0;

  logic [31:0] acc_m;
  logic [31:0] tw_m;
  logic [31:0] ld_word;
  logic        ld_active;
  logic        pend_m;
  logic        loaded_m;
  int          ld_edges;
  int          n_loaded;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, got, exp);
    end
  endtask

  function automatic logic [31:0] word_of(input logic [11:0] a);
    logic [31:0] c;
    c = (a > 12'd1800) ? 32'd1800 : {20'd0, a};
    return c * 32'd2237;
  endfunction

  task automatic model_reset();
    acc_m     = 32'd0;
    tw_m      = 32'd0;
    ld_word   = 32'd0;
    ld_active = 1'b0;
    pend_m    = 1'b0;
    loaded_m  = 1'b0;
    ld_edges  = 0;
  endtask

  // One clock edge: advance the model, then compare all outputs just after the edge.
  task automatic step();
    logic [32:0] s;
    logic [31:0] tw_old;
    @(posedge clk);
    tw_old   = tw_m;
    s        = {1'b0, acc_m} + {1'b0, tw_m};
    acc_m    = s[31:0];
    loaded_m = 1'b0;
    if (ld_active) begin
      if (ld_edges == 12 && (s[32] || tw_old == 32'd0)) begin
        tw_m     = ld_word;
        loaded_m = 1'b1;
        n_loaded++;
        if (pend_m || fc) begin
          ld_word  = word_of(addr);
          ld_edges = 0;
          pend_m   = 1'b0;
        end else begin
          ld_active = 1'b0;
        end
      end else begin
        if (ld_edges < 12) ld_edges++;
        if (fc) pend_m = 1'b1;
      end
    end else if (fc) begin
      ld_active = 1'b1;
      ld_word   = word_of(addr);
      ld_edges  = 0;
    end
    #1;
    check("phase_out", {20'd0, phase_out}, {20'd0, acc_m[31:20]});
    check("tune_word", tune_word, tw_m);
    check("busy", {31'd0, busy}, {31'd0, ld_active});
    check("loaded", {31'd0, loaded}, {31'd0, loaded_m});
  endtask

  task automatic pulse_load(input logic [11:0] a);
    addr = a;
    fc   = 1'b1;
    step();
    fc   = 1'b0;
  endtask

  task automatic run_until_idle(input string name, input int budget);
    int n;
    n = 0;
    while (ld_active && n < budget) begin
      step();
      n++;
    end
    if (ld_active) begin
      checks++;
      errors++;
      $display("FAIL %s timeout: still busy after %0d cycles, required idle", name, budget);
    end
  endtask

  initial begin
    vecs[0] = '{addr: 12'd100,  tw: 32'd223700};
    vecs[1] = '{addr: 12'd1800, tw: 32'd4026600};
    vecs[2] = '{addr: 12'd4095, tw: 32'd4026600};
    vecs[3] = '{addr: 12'd1234, tw: 32'd2760458};
    vecs[4] = '{addr: 12'd0,    tw: 32'd0};

    rst_n    = 1'b0;
    addr     = 12'd0;
    fc       = 1'b0;
    n_loaded = 0;
    model_reset();
    repeat (5) @(posedge clk);
    #1;
    check("rst_phase", {20'd0, phase_out}, 32'd0);
    check("rst_tune_word", tune_word, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_loaded", {31'd0, loaded}, 32'd0);
    rst_n = 1'b1;
    repeat (100) step();

    // Sequential loads; the 1800 load from 223700 must wait for a real carry-out.
    for (int i = 0; i < 5; i++) begin
      pulse_load(vecs[i].addr);
      run_until_idle("table_load", 25000);
      check("table_tw", tune_word, vecs[i].tw);
      repeat (3) step();
    end

    // Collision starting from a zero word: addresses scaled up so the second commit's wrap comes quickly.
    n_loaded = 0;
    pulse_load(12'd1000);
    repeat (4) step();
    pulse_load(12'd1200);
    repeat (2) step();
    pulse_load(12'd1500);
    repeat (5) step();
    check("coll_first_tw", tune_word, 32'd2237000);
    check("coll_busy_held", {31'd0, busy}, 32'd1);
    run_until_idle("coll_second", 5000);
    check("coll_second_tw", tune_word, 32'd3355500);
    check("coll_loaded_count", n_loaded, 32'd2);

    // Asynchronous reset in the middle of a multiply.
    pulse_load(12'd500);
    repeat (5) step();
    #3 rst_n = 1'b0;
    #1;
    check("async_phase", {20'd0, phase_out}, 32'd0);
    check("async_tune_word", tune_word, 32'd0);
    check("async_busy", {31'd0, busy}, 32'd0);
    check("async_loaded", {31'd0, loaded}, 32'd0);
    model_reset();
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    n_loaded = 0;
    repeat (30) step();
    check("no_commit_tw", tune_word, 32'd0);
    check("no_commit_count", n_loaded, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
